// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bundle: instruction-memory port, decode handoff and execute redirect.
interface ifetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        instr_ready;

    logic        PCSrc;
    logic [31:0] PCTarget;

    modport master (
        output imem_req, imem_addr, Instr, PC, PCPlus4, instr_valid,
        input  imem_rvalid, imem_rdata, instr_ready, PCSrc, PCTarget
    );

    modport slave (
        input  imem_req, imem_addr, Instr, PC, PCPlus4, instr_valid,
        output imem_rvalid, imem_rdata, instr_ready, PCSrc, PCTarget
    );

endinterface

// File: rtl/ifetch_flopenr.sv
// Enabled register with synchronous reset to a parameterised value.
module flopenr #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_o <= RESET_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and
// holds the returned word until decode accepts it; execute redirects may kill a fetch.
module ifetch #(
    parameter logic [31:0] RESET_PC  = ifetch_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = ifetch_pkg::NOP_INSTR
) (
    input  logic      clk,
    input  logic      reset,
    ifetch_if.master  bus
);
    import ifetch_pkg::*;

    fetch_state_t state_q, state_d;
    logic         kill_q, kill_d;
    logic         pc_en, instr_en;
    logic [31:0]  pc_d, pc_q, pc_plus4;
    logic [31:0]  instr_d, instr_q;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        pc_en    = 1'b0;
        pc_d     = pc_q;
        instr_en = 1'b0;
        instr_d  = instr_q;

        if (bus.PCSrc) begin
            pc_en    = 1'b1;
            pc_d     = bus.PCTarget & ~32'd3;
            instr_en = 1'b1;
            instr_d  = NOP_INSTR;
            state_d  = FETCH;
            // In FETCH a pending request must be killed unless its response
            // is arriving right now (in which case it is simply dropped).
            if (state_q == FETCH) begin
                kill_d = ~bus.imem_rvalid;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (bus.imem_rvalid) begin
                        if (kill_q) begin
                            kill_d = 1'b0;
                        end else begin
                            instr_en = 1'b1;
                            instr_d  = bus.imem_rdata;
                            state_d  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        pc_en    = 1'b1;
                        pc_d     = pc_plus4;
                        instr_en = 1'b1;
                        instr_d  = NOP_INSTR;
                        state_d  = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    flopenr #(
        .DATA_W   (32),
        .RESET_VAL(RESET_PC)
    ) u_pc (
        .clk  (clk),
        .reset(reset),
        .en_i (pc_en),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    flopenr #(
        .DATA_W   (32),
        .RESET_VAL(NOP_INSTR)
    ) u_instr (
        .clk  (clk),
        .reset(reset),
        .en_i (instr_en),
        .d_i  (instr_d),
        .q_o  (instr_q)
    );

    assign bus.imem_req    = (state_q == FETCH) && !kill_q;
    assign bus.imem_addr   = {pc_q[31:2], 2'b00};
    assign bus.Instr       = instr_q;
    assign bus.PC          = pc_q;
    assign bus.PCPlus4     = pc_plus4;
    assign bus.instr_valid = (state_q == HOLD);

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a latency-programmable instruction-memory responder.
module tb_ifetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    int   lat;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic        busy;
    int          cnt;
    logic [31:0] raddr;

    ifetch_if bus ();

    ifetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1234_0000 | {16'h0000, a[15:0]};
    endfunction

    // Memory model: accepts a request the edge after it is seen, answers after lat cycles.
    always @(posedge clk) begin
        if (reset) begin
            busy            <= 1'b0;
            cnt             <= 0;
            raddr           <= 32'h0;
            bus.imem_rvalid <= 1'b0;
            bus.imem_rdata  <= 32'hDEAD_BEEF;
        end else begin
            bus.imem_rvalid <= 1'b0;
            bus.imem_rdata  <= 32'hDEAD_BEEF;
            if (busy) begin
                if (cnt == 1) begin
                    bus.imem_rvalid <= 1'b1;
                    bus.imem_rdata  <= word(raddr);
                    busy            <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (bus.imem_req && !bus.imem_rvalid) begin
                if (lat == 1) begin
                    bus.imem_rvalid <= 1'b1;
                    bus.imem_rdata  <= word(bus.imem_addr);
                end else begin
                    busy  <= 1'b1;
                    cnt   <= lat - 1;
                    raddr <= bus.imem_addr;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset           = 1'b1;
        lat             = 1;
        bus.instr_ready = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.PCTarget    = 32'h0;

        tick();
        tick();
        chk("rst_pc",    bus.PC,          32'h0);
        chk("rst_instr", bus.Instr,       NOP);
        chk("rst_valid", bus.instr_valid, 32'h0);
        chk("rst_req",   bus.imem_req,    32'h0);

        // Straight-line fetch, latency 1, always ready
        reset           = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        chk("f0_req",   bus.imem_req,    32'h1);
        chk("f0_addr",  bus.imem_addr,   32'h0);
        chk("f0_valid", bus.instr_valid, 32'h0);
        tick();
        chk("f0_req_held", bus.imem_req,    32'h1);
        chk("f0_wait",     bus.instr_valid, 32'h0);
        tick();
        chk("f0_valid1", bus.instr_valid, 32'h1);
        chk("f0_instr",  bus.Instr,       32'h1234_0000);
        chk("f0_pc",     bus.PC,          32'h0);
        chk("f0_pcp4",   bus.PCPlus4,     32'h4);
        chk("f0_reqoff", bus.imem_req,    32'h0);
        tick();
        chk("f1_addr",  bus.imem_addr, 32'h4);
        chk("f1_req",   bus.imem_req,  32'h1);
        chk("f1_nop",   bus.Instr,     NOP);
        tick();
        tick();
        chk("f1_valid", bus.instr_valid, 32'h1);
        chk("f1_instr", bus.Instr,       32'h1234_0004);
        chk("f1_pc",    bus.PC,          32'h4);
        tick();
        chk("f2_addr", bus.imem_addr, 32'h8);
        chk("f2_req",  bus.imem_req,  32'h1);

        // Backpressure in HOLD
        bus.instr_ready = 1'b0;
        tick();
        tick();
        chk("bp_instr", bus.Instr,       32'h1234_0008);
        chk("bp_pc",    bus.PC,          32'h8);
        chk("bp_valid", bus.instr_valid, 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_instr", bus.Instr,       32'h1234_0008);
            chk("bp_hold_pc",    bus.PC,          32'h8);
            chk("bp_hold_req",   bus.imem_req,    32'h0);
            chk("bp_hold_valid", bus.instr_valid, 32'h1);
        end
        bus.instr_ready = 1'b1;
        tick();
        chk("bp_next_addr",  bus.imem_addr,   32'hC);
        chk("bp_next_req",   bus.imem_req,    32'h1);
        chk("bp_next_valid", bus.instr_valid, 32'h0);
        tick();
        tick();
        chk("rd_pre_valid", bus.instr_valid, 32'h1);
        chk("rd_pre_instr", bus.Instr,       32'h1234_000C);

        // Redirect in HOLD with ready also high
        bus.PCSrc    = 1'b1;
        bus.PCTarget = 32'h0000_0103;
        tick();
        bus.PCSrc = 1'b0;
        chk("rd_valid", bus.instr_valid, 32'h0);
        chk("rd_instr", bus.Instr,       NOP);
        chk("rd_pc",    bus.PC,          32'h100);
        chk("rd_addr",  bus.imem_addr,   32'h100);
        chk("rd_req",   bus.imem_req,    32'h1);
        tick();
        chk("rd_valid2", bus.instr_valid, 32'h0);
        chk("rd_addr2",  bus.imem_addr,   32'h100);
        tick();
        chk("rd_instr2", bus.Instr,       32'h1234_0100);
        chk("rd_valid3", bus.instr_valid, 32'h1);

        // Kill an in-flight fetch at 0x20 (latency 4)
        bus.PCSrc    = 1'b1;
        bus.PCTarget = 32'h0000_0020;
        lat          = 4;
        tick();
        bus.PCSrc = 1'b0;
        chk("k_addr", bus.imem_addr, 32'h20);
        chk("k_req",  bus.imem_req,  32'h1);
        tick();
        chk("k_req2",  bus.imem_req,  32'h1);
        chk("k_addr2", bus.imem_addr, 32'h20);
        bus.PCSrc    = 1'b1;
        bus.PCTarget = 32'h0000_0080;
        tick();
        bus.PCSrc = 1'b0;
        chk("k_reqoff", bus.imem_req,    32'h0);
        chk("k_pc",     bus.PC,          32'h80);
        chk("k_instr",  bus.Instr,       NOP);
        chk("k_valid",  bus.instr_valid, 32'h0);
        tick();
        chk("k_reqoff2", bus.imem_req, 32'h0);
        chk("k_instr2",  bus.Instr,    NOP);
        tick();
        chk("k_stale_rv", bus.imem_rvalid, 32'h1);
        chk("k_reqoff3",  bus.imem_req,    32'h0);
        lat = 1;
        tick();
        chk("k_new_req",  bus.imem_req,    32'h1);
        chk("k_new_addr", bus.imem_addr,   32'h80);
        chk("k_instr3",   bus.Instr,       NOP);
        chk("k_valid3",   bus.instr_valid, 32'h0);
        tick();
        tick();
        chk("k_got_valid", bus.instr_valid, 32'h1);
        chk("k_got_instr", bus.Instr,       32'h1234_0080);
        chk("k_got_pc",    bus.PC,          32'h80);

        // Redirect coincident with rvalid
        tick();
        chk("c_addr", bus.imem_addr, 32'h84);
        tick();
        chk("c_rv", bus.imem_rvalid, 32'h1);
        bus.PCSrc    = 1'b1;
        bus.PCTarget = 32'h0000_0200;
        tick();
        bus.PCSrc = 1'b0;
        chk("c_taddr", bus.imem_addr,   32'h200);
        chk("c_treq",  bus.imem_req,    32'h1);
        chk("c_instr", bus.Instr,       NOP);
        chk("c_valid", bus.instr_valid, 32'h0);
        tick();
        chk("c_nokill_req", bus.imem_req,  32'h1);
        chk("c_addr2",      bus.imem_addr, 32'h200);
        tick();
        chk("c_got_instr", bus.Instr,       32'h1234_0200);
        chk("c_got_valid", bus.instr_valid, 32'h1);
        chk("c_got_pc",    bus.PC,          32'h200);

        // PC wrap through 0xFFFF_FFFC
        bus.PCSrc    = 1'b1;
        bus.PCTarget = 32'hFFFF_FFFE;
        tick();
        bus.PCSrc = 1'b0;
        chk("w_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("w_pcp4", bus.PCPlus4,   32'h0);
        tick();
        tick();
        chk("w_instr", bus.Instr, 32'h1234_FFFC);
        chk("w_pc",    bus.PC,    32'hFFFF_FFFC);
        tick();
        chk("w_wrap_addr", bus.imem_addr, 32'h0);
        chk("w_wrap_req",  bus.imem_req,  32'h1);
        tick();
        tick();
        chk("w_instr0", bus.Instr, 32'h1234_0000);
        chk("w_pc0",    bus.PC,    32'h0);
        tick();
        chk("w_addr4", bus.imem_addr, 32'h4);

        // Reset in the middle of a fetch with a response pending
        lat = 4;
        tick();
        chk("mr_req_pre", bus.imem_req, 32'h1);
        reset = 1'b1;
        tick();
        chk("mr_pc",    bus.PC,          32'h0);
        chk("mr_valid", bus.instr_valid, 32'h0);
        chk("mr_instr", bus.Instr,       NOP);
        chk("mr_req",   bus.imem_req,    32'h0);
        tick();
        reset = 1'b0;
        lat   = 1;
        tick();
        chk("rec_req",  bus.imem_req,  32'h1);
        chk("rec_addr", bus.imem_addr, 32'h0);
        tick();
        tick();
        chk("rec_instr", bus.Instr,       32'h1234_0000);
        chk("rec_valid", bus.instr_valid, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
